// File: rtl/smg_multi_display.sv
// Multiplexed seven-segment display driver with brightness control and frame-synchronous updates.
// Latency: SmgData and ScanSig are registered and reflect the previous cycle's Idx/DivCnt. FrameDone is high for the cycle after each frame boundary.
// Backpressure: none. LoadEn is always accepted, and when several loads arrive in one frame the last one wins.
//
// Ports:
//   CLK, RST             rising-edge clock and synchronous active-high reset
//   LoadEn               one-cycle strobe that captures NumberSig/DotSig/BlankLead
//   NumberSig            hex nibbles, where nibble i is digit i and digit 0 is least significant
//   DotSig               decimal point per digit (1 = lit)
//   BlankLead            suppresses leading zeros when set
//   Bright               brightness 0..15, sampled live on every cycle
//   SmgData              segments {dp,g,f,e,d,c,b,a}; polarity is set by SEG_ACTIVE_LOW
//   ScanSig              one-hot digit select; polarity is set by SCAN_ACTIVE_LOW
//   FrameDone            one-cycle pulse at the end of each full scan frame
module smg_multi_display #(
   parameter int DIGITS          = 4,
   parameter int SCAN_DIV        = 50000,
   parameter bit SEG_ACTIVE_LOW  = 1'b1,
   parameter bit SCAN_ACTIVE_LOW = 1'b0
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  LoadEn,
   input  logic [4*DIGITS-1:0]   NumberSig,
   input  logic [DIGITS-1:0]     DotSig,
   input  logic                  BlankLead,
   input  logic [3:0]            Bright,
   output logic [7:0]            SmgData,
   output logic [DIGITS-1:0]     ScanSig,
   output logic                  FrameDone
);

   localparam int DW        = $clog2(SCAN_DIV);
   localparam int SLICE_LEN = SCAN_DIV / 16;
   localparam int SW        = (SLICE_LEN > 1) ? $clog2(SLICE_LEN) : 1;
   localparam int IW        = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [DW-1:0] DIV_MAX   = DW'(SCAN_DIV - 1);
   localparam logic [SW-1:0] SLICE_MAX = SW'(SLICE_LEN - 1);
   localparam logic [IW-1:0] IDX_MAX   = IW'(DIGITS - 1);

   // Everything one LoadEn captures, kept together so pending and display buffers match
   typedef struct packed {
      logic [4*DIGITS-1:0] num;
      logic [DIGITS-1:0]   dot;
      logic                blank;
   } dispRec_t;

   logic [DW-1:0]     DivCnt;
   logic [IW-1:0]     Idx;
   logic [SW-1:0]     sliceCnt;
   logic [3:0]        slice;
   dispRec_t          dispBuf;
   dispRec_t          pendBuf;
   dispRec_t          loadRec;
   logic              Pending;
   logic              frameEnd;
   logic              active;
   logic [7:0]        segReg;
   logic [DIGITS-1:0] scanReg;

   logic [DIGITS-1:0] blankVec;
   logic              zeroAbove;
   logic [3:0]        curNib;
   logic              curDot;
   logic              curBlank;

   function automatic logic [6:0] hexSeg(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         default: s = 7'h71;
      endcase
      return s;
   endfunction

   assign loadRec  = '{num: NumberSig, dot: DotSig, blank: BlankLead};
   assign frameEnd = (Idx == IDX_MAX) && (DivCnt == DIV_MAX);
   // The first cycle of every slot stays dark so the previous digit's segments never ghost onto the next one
   assign active   = (slice <= Bright) && (DivCnt != '0);

   // Leading-zero mask: a digit is blank when it and every higher nibble are zero. Digit 0 is never blanked.
   always_comb begin
      blankVec  = '0;
      zeroAbove = 1'b1;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         zeroAbove   = zeroAbove & (dispBuf.num[4*i +: 4] == 4'h0);
         blankVec[i] = dispBuf.blank && (i != 0) && zeroAbove;
      end
   end

   always_comb begin
      curNib   = 4'h0;
      curDot   = 1'b0;
      curBlank = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (Idx == IW'(i)) begin
            curNib   = dispBuf.num[4*i +: 4];
            curDot   = dispBuf.dot[i];
            curBlank = blankVec[i];
         end
      end
   end

   // Slot, digit and sub-slice counters. The sub-slice counter wraps in step with DivCnt
   // because SCAN_DIV is exactly 16 sub-slices long.
   always_ff @(posedge CLK) begin
      if (RST) begin
         DivCnt   <= '0;
         Idx      <= '0;
         sliceCnt <= '0;
         slice    <= 4'd0;
      end else begin
         if (DivCnt == DIV_MAX) begin
            DivCnt <= '0;
            Idx    <= (Idx == IDX_MAX) ? '0 : Idx + 1'b1;
         end else begin
            DivCnt <= DivCnt + 1'b1;
         end
         if (sliceCnt == SLICE_MAX) begin
            sliceCnt <= '0;
            slice    <= slice + 4'd1;
         end else begin
            sliceCnt <= sliceCnt + 1'b1;
         end
      end
   end

   // Pending and display buffers. The display buffer changes only at a frame boundary.
   always_ff @(posedge CLK) begin
      if (RST) begin
         dispBuf <= '0;
         pendBuf <= '0;
         Pending <= 1'b0;
      end else if (frameEnd) begin
         if (LoadEn) begin
            dispBuf <= loadRec;
         end else if (Pending) begin
            dispBuf <= pendBuf;
         end
         Pending <= 1'b0;
      end else if (LoadEn) begin
         pendBuf <= loadRec;
         Pending <= 1'b1;
      end
   end

   // Output registers. Segments are forced off whenever no digit is selected.
   always_ff @(posedge CLK) begin
      if (RST) begin
         segReg    <= 8'h00;
         scanReg   <= '0;
         FrameDone <= 1'b0;
      end else begin
         FrameDone <= frameEnd;
         segReg    <= active ? {curDot, (curBlank ? 7'h00 : hexSeg(curNib))} : 8'h00;
         scanReg   <= active ? (DIGITS'(1) << Idx) : '0;
      end
   end

   assign SmgData = SEG_ACTIVE_LOW  ? ~segReg  : segReg;
   assign ScanSig = SCAN_ACTIVE_LOW ? ~scanReg : scanReg;

endmodule

// File: tb/tb_smg_multi_display.sv
// Testbench for smg_multi_display with DIGITS=4, SCAN_DIV=16 and active-high polarity.
// Each cycle the bench predicts the next outputs from its own frame position and display contents and pushes the prediction to a queue.
// One cycle later the bench pops the prediction and compares it against the DUT.
module tb_smg_multi_display;

   logic        CLK = 1'b0;
   logic        RST;
   logic        LoadEn;
   logic [15:0] NumberSig;
   logic [3:0]  DotSig;
   logic        BlankLead;
   logic [3:0]  Bright;
   logic [7:0]  SmgData;
   logic [3:0]  ScanSig;
   logic        FrameDone;

   smg_multi_display #(
      .DIGITS(4), .SCAN_DIV(16), .SEG_ACTIVE_LOW(1'b0), .SCAN_ACTIVE_LOW(1'b0)
   ) dut (
      .CLK(CLK), .RST(RST), .LoadEn(LoadEn), .NumberSig(NumberSig), .DotSig(DotSig),
      .BlankLead(BlankLead), .Bright(Bright), .SmgData(SmgData), .ScanSig(ScanSig),
      .FrameDone(FrameDone)
   );

   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [7:0] seg;
      logic [3:0] scan;
      logic       fd;
   } obs_t;

   // Expected bytes per digit: seg[0] is digit 0, written as {d3,d2,d1,d0}
   typedef struct packed {
      logic [15:0]     num;
      logic [3:0]      dot;
      logic            blank;
      logic [3:0]      bright;
      logic [3:0][7:0] seg;
   } vec_t;

   vec_t            vecs[7];
   obs_t            sbq[$];
   int              checks = 0;
   int              failures = 0;
   int              ph = 0;
   int              fdCount = 0;
   logic [3:0][7:0] dispModel;
   logic [3:0][7:0] pendModel;
   logic [3:0][7:0] loadSeg;
   logic            pendModelVld = 1'b0;

   task automatic step(input string tag);
      obs_t e;
      obs_t got;
      int   slot;
      int   idx;
      int   phNow;
      logic act;
      phNow = ph;
      slot  = ph % 16;
      idx   = ph / 16;
      if (RST) begin
         e            = '0;
         ph           = 0;
         dispModel    = {4{8'h3F}};
         pendModelVld = 1'b0;
      end else begin
         act    = (slot != 0) && (slot <= int'(Bright));
         e.seg  = act ? dispModel[idx] : 8'h00;
         e.scan = act ? 4'(1 << idx) : 4'h0;
         e.fd   = (ph == 63);
         if (ph == 63) begin
            if (LoadEn) dispModel = loadSeg;
            else if (pendModelVld) dispModel = pendModel;
            pendModelVld = 1'b0;
         end else if (LoadEn) begin
            pendModel    = loadSeg;
            pendModelVld = 1'b1;
         end
         ph = (ph + 1) % 64;
      end
      sbq.push_back(e);
      @(negedge CLK);
      got = {SmgData, ScanSig, FrameDone};
      e   = sbq.pop_front();
      checks++;
      if (got.fd) fdCount++;
      if (got !== e) begin
         failures++;
         $display("FAIL %s ph=%0d: got seg=%h scan=%b fd=%b, expected seg=%h scan=%b fd=%b",
                  tag, phNow, got.seg, got.scan, got.fd, e.seg, e.scan, e.fd);
      end
   endtask

   task automatic idle();
      NumberSig = 16'($urandom);
      DotSig    = 4'($urandom);
      BlankLead = 1'($urandom);
      step("scan");
   endtask

   task automatic runCycles(input int n);
      for (int k = 0; k < n; k++) idle();
   endtask

   task automatic runTo(input int t);
      while (ph != t) idle();
   endtask

   task automatic load(input vec_t v, input string tag);
      NumberSig = v.num;
      DotSig    = v.dot;
      BlankLead = v.blank;
      Bright    = v.bright;
      loadSeg   = v.seg;
      LoadEn    = 1'b1;
      step(tag);
      LoadEn    = 1'b0;
   endtask

   initial begin
      vecs[0] = '{16'h1234, 4'b0000, 1'b0, 4'd15, {8'h06, 8'h5B, 8'h4F, 8'h66}};
      vecs[1] = '{16'h0070, 4'b0001, 1'b1, 4'd15, {8'h00, 8'h00, 8'h07, 8'hBF}};
      vecs[2] = '{16'hABCD, 4'b1010, 1'b0, 4'd7,  {8'hF7, 8'h7C, 8'hB9, 8'h5E}};
      vecs[3] = '{16'hEF09, 4'b0000, 1'b1, 4'd3,  {8'h79, 8'h71, 8'h3F, 8'h6F}};
      vecs[4] = '{16'h0000, 4'b1000, 1'b1, 4'd15, {8'h80, 8'h00, 8'h00, 8'h3F}};
      vecs[5] = '{16'h5678, 4'b0000, 1'b0, 4'd0,  {8'h6D, 8'h7D, 8'h07, 8'h7F}};
      vecs[6] = '{16'h0100, 4'b0000, 1'b1, 4'd10, {8'h00, 8'h06, 8'h3F, 8'h3F}};

      RST = 1'b1; LoadEn = 1'b0; NumberSig = '0; DotSig = '0; BlankLead = 1'b0; Bright = 4'd15;
      repeat (2) @(negedge CLK);
      repeat (3) step("reset");
      RST = 1'b0;
      runCycles(70);

      // Table: load mid-frame; the new value appears only after the next boundary
      for (int v = 0; v < 7; v++) begin
         runTo(20);
         load(vecs[v], "table_load");
         runCycles(110);
      end

      // Two mid-frame loads: the last one wins. Then count FrameDone pulses.
      runTo(10);
      load('{16'h1111, 4'b0000, 1'b0, 4'd15, {4{8'h06}}}, "load_1111");
      runTo(30);
      load('{16'h2222, 4'b0000, 1'b0, 4'd15, {4{8'h5B}}}, "load_2222");
      fdCount = 0;
      runCycles(128);
      checks++;
      if (fdCount != 2) begin
         failures++;
         $display("FAIL frame_done_count: got %0d pulses in 128 cycles, expected 2", fdCount);
      end

      // Load on the boundary cycle: the value is shown directly from the next frame
      runTo(63);
      load('{16'h4321, 4'b0000, 1'b0, 4'd15, {8'h66, 8'h4F, 8'h5B, 8'h06}}, "load_boundary");
      runCycles(130);

      // Reset mid-frame with a pending load; a load during reset is ignored
      runTo(5);
      load('{16'h9999, 4'b1111, 1'b0, 4'd15, {4{8'hEF}}}, "load_pending");
      runTo(20);
      RST = 1'b1;
      step("reset_mid");
      NumberSig = 16'h8888; loadSeg = {4{8'h7F}}; LoadEn = 1'b1;
      step("reset_load");
      LoadEn = 1'b0;
      step("reset_mid");
      RST = 1'b0;
      runCycles(140);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
